// File: rtl/r_ptr_empty_fwft.sv
// rtl/r_ptr_empty_fwft.sv - async FIFO read side: Gray pointer, registered empty flag, FWFT output buffer.
// Optional macro R_PTR_LEVEL_EN adds a registered r_level (unfetched words in RAM).
module r_ptr_empty_fwft #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  r_clk,
  input  logic                  r_rst,
  input  logic [ADDR_WIDTH:0]   r_q2_w_ptr,
  input  logic [DATA_WIDTH-1:0] r_mem_data,
  input  logic                  r_ready,
  output logic                  r_mem_en,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic [ADDR_WIDTH:0]   r_ptr,
  output logic                  r_empty,
  output logic                  r_valid,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic [ADDR_WIDTH:0]   r_level
);

  typedef enum logic [1:0] {B0, B1, B2} buf_state_t;

  buf_state_t            state, state_next;
  logic [ADDR_WIDTH:0]   r_bin, r_bin_next, r_gray_next;
  logic [1:0]            cnt, cnt_next;
  logic                  arrival, pop;
  logic [DATA_WIDTH-1:0] head, skid, head_next, skid_next;

  assign pop         = r_valid & r_ready;
  assign r_valid     = (state != B0);
  assign r_data      = head;
  assign r_addr      = r_bin[ADDR_WIDTH-1:0];
  // cnt covers buffered plus in-flight words, so a fetch is only issued when a slot is guaranteed
  assign r_mem_en    = ~r_empty & ((cnt < 2'd2) | pop);
  assign r_bin_next  = r_bin + {{ADDR_WIDTH{1'b0}}, r_mem_en};
  assign r_gray_next = (r_bin_next >> 1) ^ r_bin_next;
  assign cnt_next    = cnt + {1'b0, r_mem_en} - {1'b0, pop};

  always_comb begin
    state_next = state;
    head_next  = head;
    skid_next  = skid;
    case (state)
      B0: if (arrival) begin
        state_next = B1;
        head_next  = r_mem_data;
      end
      B1: begin
        if (arrival && !pop) begin
          state_next = B2;
          skid_next  = r_mem_data;
        end else if (arrival && pop) begin
          head_next = r_mem_data;
        end else if (pop) begin
          state_next = B0;
        end
      end
      B2: if (pop) begin
        state_next = B1;
        head_next  = skid;
      end
      default: state_next = B0;
    endcase
  end

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      r_bin   <= '0;
      r_ptr   <= '0;
      r_empty <= 1'b1;
      cnt     <= 2'd0;
      arrival <= 1'b0;
      state   <= B0;
      head    <= '0;
      skid    <= '0;
    end else begin
      r_bin   <= r_bin_next;
      r_ptr   <= r_gray_next;
      r_empty <= (r_gray_next == r_q2_w_ptr);
      cnt     <= cnt_next;
      arrival <= r_mem_en;
      state   <= state_next;
      head    <= head_next;
      skid    <= skid_next;
    end
  end

`ifdef R_PTR_LEVEL_EN
  logic [ADDR_WIDTH:0] w_bin;

  always_comb begin
    w_bin = '0;
    for (int i = 0; i <= ADDR_WIDTH; i++) w_bin[i] = ^(r_q2_w_ptr >> i);
  end

  always_ff @(posedge r_clk) begin
    if (r_rst) r_level <= '0;
    else       r_level <= w_bin - r_bin_next;
  end
`else
  assign r_level = '0;
`endif

endmodule

// File: tb/tb_r_ptr_empty_fwft.sv
// tb/tb_r_ptr_empty_fwft.sv - directed bench for r_ptr_empty_fwft with a 1-cycle RAM model.
module tb_r_ptr_empty_fwft;

  logic       clk = 1'b0;
  logic       r_rst, r_ready, r_mem_en, r_empty, r_valid;
  logic [4:0] r_q2_w_ptr, r_ptr, r_level;
  logic [7:0] r_mem_data, r_data;
  logic [3:0] r_addr;
  logic [7:0] mem [16];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  r_ptr_empty_fwft #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .r_clk(clk), .r_rst(r_rst), .r_q2_w_ptr(r_q2_w_ptr), .r_mem_data(r_mem_data),
    .r_ready(r_ready), .r_mem_en(r_mem_en), .r_addr(r_addr), .r_ptr(r_ptr),
    .r_empty(r_empty), .r_valid(r_valid), .r_data(r_data), .r_level(r_level)
  );

  initial r_mem_data = 8'h00;
  always @(posedge clk) if (r_mem_en) r_mem_data <= mem[r_addr];

  function automatic logic [4:0] gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset;
    r_rst = 1'b1;
    tick();
    r_rst = 1'b0;
    #1;
  endtask

  initial begin
    int strobes, s, w, p, gaps, wraps;
    logic saw_wrap;
    logic [4:0] prev_ptr;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    r_ready = 1'b1;
    r_q2_w_ptr = 5'd0;
    tick();

    // 1: reset state and idle
    do_reset();
    chk("rst_empty", r_empty, 1);
    chk("rst_valid", r_valid, 0);
    chk("rst_ptr", r_ptr, 0);
    chk("rst_data", r_data, 0);
    chk("rst_level", r_level, 0);
    chk("rst_mem_en", r_mem_en, 0);
    chk("rst_addr", r_addr, 0);
    for (int k = 0; k < 10; k++) begin
      chk("idle_empty", r_empty, 1);
      chk("idle_valid", r_valid, 0);
      chk("idle_mem_en", r_mem_en, 0);
      chk("idle_ptr", r_ptr, 0);
      tick();
    end

    // 2: three words, back to back
    mem[0] = 8'hA0; mem[1] = 8'hA1; mem[2] = 8'hA2;
    r_q2_w_ptr = gray(5'd3);
    #1;
    chk("t2_c0_mem_en", r_mem_en, 0);
    tick();
    chk("t2_c1_empty", r_empty, 0);
    chk("t2_c1_mem_en", r_mem_en, 1);
    chk("t2_c1_addr", r_addr, 0);
    tick();
    chk("t2_c2_mem_en", r_mem_en, 1);
    chk("t2_c2_addr", r_addr, 1);
    chk("t2_c2_valid", r_valid, 0);
    tick();
    chk("t2_c3_valid", r_valid, 1);
    chk("t2_c3_data", r_data, 8'hA0);
    chk("t2_c3_mem_en", r_mem_en, 1);
    chk("t2_c3_addr", r_addr, 2);
    tick();
    chk("t2_c4_empty", r_empty, 1);
    chk("t2_c4_valid", r_valid, 1);
    chk("t2_c4_data", r_data, 8'hA1);
    chk("t2_c4_mem_en", r_mem_en, 0);
    tick();
    chk("t2_c5_valid", r_valid, 1);
    chk("t2_c5_data", r_data, 8'hA2);
    chk("t2_c5_mem_en", r_mem_en, 0);
    tick();
    chk("t2_c6_valid", r_valid, 0);
    chk("t2_c6_ptr", r_ptr, 5'b00010);
    chk("t2_c6_empty", r_empty, 1);

    // 3: backpressure with 8 words pending, then release
    r_q2_w_ptr = 5'd0;
    do_reset();
    for (int i = 0; i < 8; i++) mem[i] = 8'hB0 + 8'(i);
    r_ready = 1'b0;
    r_q2_w_ptr = gray(5'd8);
    #1;
    strobes = 0;
    for (int k = 0; k < 10; k++) begin
      if (r_mem_en) strobes++;
      if (k >= 3) chk("t3_hold_data", r_data, 8'hB0);
      tick();
    end
    chk("t3_strobes", strobes, 2);
    chk("t3_valid", r_valid, 1);
    chk("t3_empty", r_empty, 0);
    chk("t3_bp_mem_en", r_mem_en, 0);
    r_ready = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      chk("t3_rel_valid", r_valid, 1);
      chk("t3_rel_data", r_data, 8'hB0 + 8'(i));
      tick();
    end
    chk("t3_end_valid", r_valid, 0);
    chk("t3_end_ptr", r_ptr, gray(5'd8));

    // 4: 40-word stream across two address wraps and a pointer wrap
    r_q2_w_ptr = 5'd0;
    do_reset();
    s = 0; w = 0; p = 0; gaps = 0; wraps = 0;
    saw_wrap = 1'b0;
    prev_ptr = 5'd0;
    for (int c = 0; c < 200 && p < 40; c++) begin
      while (w < 40 && (w - s) < 16) begin
        mem[w % 16] = 8'h40 + 8'(w);
        w++;
      end
      r_q2_w_ptr = gray(5'(w));
      #1;
      if (r_mem_en) begin
        chk("t4_addr", r_addr, s % 16);
        if (r_addr == 4'd0 && s > 0) wraps++;
        s++;
      end
      if (r_valid) begin
        chk("t4_data", r_data, 8'h40 + 8'(p));
        p++;
      end else if (p > 0) begin
        gaps++;
      end
      if (prev_ptr == 5'd16 && r_ptr == 5'd0) saw_wrap = 1'b1;
      prev_ptr = r_ptr;
      tick();
    end
    chk("t4_pops", p, 40);
    chk("t4_gaps", gaps, 0);
    chk("t4_addr_wraps", wraps, 2);
    chk("t4_ptr_wrap", saw_wrap, 1);
    chk("t4_end_ptr", r_ptr, gray(5'd8));
    chk("t4_end_empty", r_empty, 1);

    // 5: reset with two words held/in flight
    r_q2_w_ptr = 5'd0;
    do_reset();
    for (int i = 0; i < 6; i++) mem[i] = 8'hC0 + 8'(i);
    r_ready = 1'b0;
    r_q2_w_ptr = gray(5'd6);
    for (int k = 0; k < 4; k++) tick();
    chk("t5_pre_valid", r_valid, 1);
    r_rst = 1'b1;
    r_ready = 1'b1;
    r_q2_w_ptr = 5'd0;
    tick();
    r_rst = 1'b0;
    #1;
    chk("t5_valid", r_valid, 0);
    chk("t5_ptr", r_ptr, 0);
    chk("t5_empty", r_empty, 1);
    for (int k = 0; k < 4; k++) begin
      chk("t5_stale_valid", r_valid, 0);
      chk("t5_stale_mem_en", r_mem_en, 0);
      tick();
    end

    // 6: fill level with 16 words written and 2 fetched
    do_reset();
    r_ready = 1'b0;
    r_q2_w_ptr = gray(5'd16);
    for (int k = 0; k < 6; k++) tick();
`ifdef R_PTR_LEVEL_EN
    chk("t6_level", r_level, 14);
`else
    chk("t6_level", r_level, 0);
`endif
    chk("t6_valid", r_valid, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
